clock_seq_ctrl: RTL and testbench
=================================

# clock_seq_ctrl

Fully synchronous sequencer for the min:sec/hour clock datapath. It debounces the three user buttons and runs a CLOCK/SETUP/ALARM mode state machine. It issues single-cycle increment enables to the time counters and the alarm registers, and drives a digit-blink mask and an alarm output. All outputs are enables or levels in the `clk` domain; no derived clocks leave this block.

## Interface
- `TICK_DIV`, 50000000: clk cycles per 1 s tick.
- `SAMPLE_DIV`, 500000: clk cycles per button sample strobe (100 Hz).
- `ALARM_SEC`, 30: seconds the alarm output stays asserted unless cleared.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `i_sw0`  in  1  mode button, active-low (0 = pressed).
- `i_sw1`  in  1  position button, active-low.
- `i_sw2`  in  1  increment button, active-low.
- `i_sec_at_max`  in  1  seconds counter == 59 (level).
- `i_min_at_max`  in  1  minutes counter == 59 (level).
- `i_alarm_match`  in  1  time == alarm time (level).
- `o_mode`  out  2  0 CLOCK, 1 SETUP, 2 ALARM.
- `o_position`  out  2  0 SEC, 1 MIN, 2 HOUR.
- `o_sec_inc`, `o_min_inc`, `o_hour_inc`  out  1 each  time counter enables, one-cycle pulses.
- `o_alm_sec_inc`, `o_alm_min_inc`, `o_alm_hour_inc`  out  1 each  alarm register enables, one-cycle pulses.
- `o_blink_mask`  out  6  1 = blank digit; [1:0] sec, [3:2] min, [5:4] hour.
- `o_alarm`  out  1  alarm ringing.

## Operation
- **Reset values:**
  - All outputs 0; mode CLOCK; position SEC.
  - Tick counter, sample counter and alarm-second counter are 0.
  - Synchronizer and sample flops preset to 1 (released), so no press is seen after reset.
- **Input path:** each switch passes through a 2-flop synchronizer. At each sample strobe the synchronized value shifts into a 2-bit sample register. A press event is a one-cycle pulse when the new sample is 0 and the previous sample was 1.
- **Sample counter:** counts 0..SAMPLE_DIV-1. The strobe is the cycle in which count == SAMPLE_DIV-1.
- **Tick counter:** counts 0..TICK_DIV-1. `sec_tick` is the cycle in which count == TICK_DIV-1. The counter is cleared on the transition out of SETUP.
- **Mode FSM** (advanced by a sw0 press): CLOCK -> SETUP -> ALARM -> CLOCK. Every mode change sets position to SEC.
- **Position** (advanced by a sw1 press, any mode): SEC -> MIN -> HOUR -> SEC.
- **CLOCK and ALARM modes (timekeeping):**
  - `o_sec_inc = sec_tick`.
  - `o_min_inc = sec_tick & i_sec_at_max`.
  - `o_hour_inc = sec_tick & i_sec_at_max & i_min_at_max`.
- **SETUP mode:**
  - `sec_tick` is suppressed.
  - A sw2 press pulses exactly one of `o_sec_inc`/`o_min_inc`/`o_hour_inc`, selected by position.
  - No carry is generated; the `at_max` inputs are ignored.
- **ALARM mode:** a sw2 press pulses one of the `o_alm_*_inc` outputs, selected by position. Time counting continues independently.
- **Blink:**
  - In CLOCK mode the mask is 0.
  - In SETUP/ALARM, the two bits of the selected position are 1 while tick count < TICK_DIV/2 (integer division), otherwise 0.
  - Unselected bits are always 0.
- **Alarm:**
  - `o_alarm` sets on a rising edge of `i_alarm_match` (registered compare) when mode != SETUP.
  - It clears on any press event or after ALARM_SEC `sec_tick`s.
  - A press that clears the alarm is consumed and has no other effect.
- **Simultaneous events:**
  - sw0 with sw1/sw2 in the same strobe: mode change only.
  - sw1 with sw2: position change only.
  - Alarm set and clear in the same cycle: clear wins.

## Timing
- Press latency: the pulse is asserted exactly 1 clk after the strobe that captures the first pressed sample. From the pin this is 2 sync cycles plus up to SAMPLE_DIV plus 1.
- Mode and position registers update in the cycle after the press pulse. Increment pulses are issued in the same cycle as the press pulse, using the current (pre-update) mode and position.
- Every `*_inc` output is high for exactly one clk per event, never two cycles back-to-back from the same press.
- Carry enables are combinational from `sec_tick` and the `at_max` levels, in the same cycle as `o_sec_inc`.
- Reset mid-press: outputs go to 0 immediately. A still-held button produces no press until it has been released and sampled at least once.
- The alarm auto-clear counter restarts at 0 on each set.

## Test plan
Bench parameters: TICK_DIV=10, SAMPLE_DIV=4, ALARM_SEC=3.
- **Reset/idle:** hold buttons released for 100 clk -> `o_sec_inc` pulses every 10 clk, first at clk 10 after reset; all other outputs 0.
- **Carry:** CLOCK mode, `i_sec_at_max`=`i_min_at_max`=1 -> `o_sec_inc`, `o_min_inc` and `o_hour_inc` pulse in the same cycle; with `i_min_at_max`=0, `o_hour_inc` stays 0.
- **Setup:**
  - Stimulus: sw0 press, then two sw1 presses, then three sw2 presses.
  - Mode goes to 1 and position reaches 2.
  - Exactly 3 `o_hour_inc` pulses; no `o_sec_inc` occurs while in SETUP.
  - `o_blink_mask` toggles between 6'b110000 and 0.
- **Alarm mode:** two sw0 presses -> mode 2, position 0; a sw2 press -> one `o_alm_sec_inc` pulse while `o_sec_inc` continues every 10 clk.
- **Alarm ring:**
  - Rising edge on `i_alarm_match` in CLOCK -> `o_alarm`=1, cleared after 3 ticks.
  - Repeat, then press sw1 -> alarm clears and position stays SEC.
  - Same match edge in SETUP -> `o_alarm` stays 0.
- **Simultaneous/reset:**
  - Press sw0 and sw2 together in SETUP -> mode becomes ALARM with no inc pulse.
  - Assert `rst_n` low mid-press -> all outputs 0; no press event until the button is released and pressed again.

Source files
------------

// File: rtl/clock_seq_ctrl_if.sv
// Signal bundle between the clock sequencer and the time/alarm datapath:
// buttons and counter status in, counter enables and display/alarm indications out.
interface clock_seq_ctrl_if;
  logic       i_sw0;
  logic       i_sw1;
  logic       i_sw2;
  logic       i_sec_at_max;
  logic       i_min_at_max;
  logic       i_alarm_match;
  logic [1:0] o_mode;
  logic [1:0] o_position;
  logic       o_sec_inc;
  logic       o_min_inc;
  logic       o_hour_inc;
  logic       o_alm_sec_inc;
  logic       o_alm_min_inc;
  logic       o_alm_hour_inc;
  logic [5:0] o_blink_mask;
  logic       o_alarm;

  modport slave (
    input  i_sw0, i_sw1, i_sw2, i_sec_at_max, i_min_at_max, i_alarm_match,
    output o_mode, o_position, o_sec_inc, o_min_inc, o_hour_inc,
           o_alm_sec_inc, o_alm_min_inc, o_alm_hour_inc, o_blink_mask, o_alarm
  );

  modport master (
    output i_sw0, i_sw1, i_sw2, i_sec_at_max, i_min_at_max, i_alarm_match,
    input  o_mode, o_position, o_sec_inc, o_min_inc, o_hour_inc,
           o_alm_sec_inc, o_alm_min_inc, o_alm_hour_inc, o_blink_mask, o_alarm
  );
endinterface

// File: rtl/clock_seq_ctrl.sv
// Clock sequencer: button debounce, CLOCK/SETUP/ALARM mode FSM, time/alarm
// increment enables, digit blink mask and alarm ringer, all in the clk domain.
module clock_seq_ctrl #(
  parameter int TICK_DIV   = 50000000,
  parameter int SAMPLE_DIV = 500000,
  parameter int ALARM_SEC  = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  clock_seq_ctrl_if.slave   bus
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int AW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_HALF   = TW'(TICK_DIV / 2);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_DIV - 1);
  localparam logic [AW-1:0] ALARM_LAST  = AW'(ALARM_SEC - 1);

  typedef enum logic [1:0] {
    MODE_CLOCK = 2'd0,
    MODE_SETUP = 2'd1,
    MODE_ALARM = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    POS_SEC  = 2'd0,
    POS_MIN  = 2'd1,
    POS_HOUR = 2'd2
  } pos_t;

  mode_t         mode_reg, mode_next;
  pos_t          pos_reg, pos_next;
  logic [TW-1:0] tick_cnt_reg;
  logic [SW-1:0] samp_cnt_reg;
  logic [AW-1:0] alm_cnt_reg;
  logic          alarm_reg;
  logic          match_d_reg;
  logic          strobe_d_reg;

  logic [2:0] sw_pins;
  logic [2:0] press;
  logic       strobe, sec_tick, tick_clear;
  logic       any_press, consume, ev_mode, ev_pos, ev_inc;
  logic       alarm_set, alarm_clear;
  logic       sec_inc, min_inc, hour_inc;
  logic       alm_sec_inc, alm_min_inc, alm_hour_inc;
  logic [5:0] blink_mask;

  assign sw_pins = {bus.i_sw2, bus.i_sw1, bus.i_sw0};
  assign strobe  = (samp_cnt_reg == SAMPLE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_cnt_reg <= '0;
      strobe_d_reg <= 1'b0;
    end else begin
      samp_cnt_reg <= strobe ? '0 : samp_cnt_reg + SW'(1);
      strobe_d_reg <= strobe;
    end
  end

  // A button only becomes eligible once a released sample has been seen, so a
  // button held through reset cannot fire until it is let go and pressed again.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic       sync1_reg, sync2_reg, armed_reg;
      logic [1:0] samp_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
          samp_reg  <= 2'b11;
          armed_reg <= 1'b0;
        end else begin
          sync1_reg <= sw_pins[gi];
          sync2_reg <= sync1_reg;
          if (strobe) begin
            samp_reg <= {samp_reg[0], sync2_reg};
            if (sync2_reg) armed_reg <= 1'b1;
          end
        end
      end

      assign press[gi] = strobe_d_reg & armed_reg & samp_reg[1] & ~samp_reg[0];
    end
  endgenerate

  // A press that silences the alarm does nothing else; sw0 outranks sw1 outranks sw2.
  assign any_press = |press;
  assign consume   = alarm_reg & any_press;
  assign ev_mode   = press[0] & ~consume;
  assign ev_pos    = press[1] & ~press[0] & ~consume;
  assign ev_inc    = press[2] & ~press[1] & ~press[0] & ~consume;

  assign sec_tick   = (tick_cnt_reg == TICK_LAST) && (mode_reg != MODE_SETUP);
  assign tick_clear = (mode_reg == MODE_SETUP) && (mode_next != MODE_SETUP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_reg <= '0;
    end else if (tick_clear || (tick_cnt_reg == TICK_LAST)) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg <= MODE_CLOCK;
      pos_reg  <= POS_SEC;
    end else begin
      mode_reg <= mode_next;
      pos_reg  <= pos_next;
    end
  end

  always_comb begin
    mode_next    = mode_reg;
    pos_next     = pos_reg;
    sec_inc      = 1'b0;
    min_inc      = 1'b0;
    hour_inc     = 1'b0;
    alm_sec_inc  = 1'b0;
    alm_min_inc  = 1'b0;
    alm_hour_inc = 1'b0;
    blink_mask   = 6'b000000;

    if (ev_mode) begin
      case (mode_reg)
        MODE_CLOCK: mode_next = MODE_SETUP;
        MODE_SETUP: mode_next = MODE_ALARM;
        default:    mode_next = MODE_CLOCK;
      endcase
      pos_next = POS_SEC;
    end else if (ev_pos) begin
      case (pos_reg)
        POS_SEC: pos_next = POS_MIN;
        POS_MIN: pos_next = POS_HOUR;
        default: pos_next = POS_SEC;
      endcase
    end

    // Increments use the mode and position in force before this press takes effect.
    if (mode_reg == MODE_SETUP) begin
      sec_inc  = ev_inc & (pos_reg == POS_SEC);
      min_inc  = ev_inc & (pos_reg == POS_MIN);
      hour_inc = ev_inc & (pos_reg == POS_HOUR);
    end else begin
      sec_inc  = sec_tick;
      min_inc  = sec_tick & bus.i_sec_at_max;
      hour_inc = sec_tick & bus.i_sec_at_max & bus.i_min_at_max;
      if (mode_reg == MODE_ALARM) begin
        alm_sec_inc  = ev_inc & (pos_reg == POS_SEC);
        alm_min_inc  = ev_inc & (pos_reg == POS_MIN);
        alm_hour_inc = ev_inc & (pos_reg == POS_HOUR);
      end
    end

    if ((mode_reg != MODE_CLOCK) && (tick_cnt_reg < TICK_HALF)) begin
      case (pos_reg)
        POS_SEC:  blink_mask = 6'b000011;
        POS_MIN:  blink_mask = 6'b001100;
        default:  blink_mask = 6'b110000;
      endcase
    end
  end

  assign alarm_set   = bus.i_alarm_match & ~match_d_reg & (mode_reg != MODE_SETUP);
  assign alarm_clear = any_press | (alarm_reg & sec_tick & (alm_cnt_reg == ALARM_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_d_reg <= 1'b0;
      alarm_reg   <= 1'b0;
      alm_cnt_reg <= '0;
    end else begin
      match_d_reg <= bus.i_alarm_match;
      if (alarm_clear) begin
        alarm_reg <= 1'b0;
      end else if (alarm_set) begin
        alarm_reg   <= 1'b1;
        alm_cnt_reg <= '0;
      end else if (alarm_reg && sec_tick) begin
        alm_cnt_reg <= alm_cnt_reg + AW'(1);
      end
    end
  end

  assign bus.o_mode         = mode_reg;
  assign bus.o_position     = pos_reg;
  assign bus.o_sec_inc      = sec_inc;
  assign bus.o_min_inc      = min_inc;
  assign bus.o_hour_inc     = hour_inc;
  assign bus.o_alm_sec_inc  = alm_sec_inc;
  assign bus.o_alm_min_inc  = alm_min_inc;
  assign bus.o_alm_hour_inc = alm_hour_inc;
  assign bus.o_blink_mask   = blink_mask;
  assign bus.o_alarm        = alarm_reg;
endmodule

// File: tb/tb_clock_seq_ctrl.sv
// Self-checking bench for clock_seq_ctrl: directed scenario sequence with random
// gaps/levels, every cycle compared against a cycle-count based reference model.
module tb_clock_seq_ctrl;
  localparam int TICK_DIV   = 10;
  localparam int SAMPLE_DIV = 4;
  localparam int ALARM_SEC  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  clock_seq_ctrl_if bus ();

  clock_seq_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .SAMPLE_DIV(SAMPLE_DIV),
    .ALARM_SEC (ALARM_SEC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: cycles since reset, tick phase origin, mode/pos, alarm.
  int   n, base, e_mode, e_pos, ring_ticks, pend_cycle;
  logic [2:0] pend_mask;
  logic e_alarm, m_prev;

  int cnt_sec, cnt_min, cnt_hour, cnt_asec, cnt_amin, cnt_ahour;
  int first_sec, last_sec, bad_gap, blink_on, blink_off, blink_other;

  task automatic model_reset();
    n = 0; base = 0; e_mode = 0; e_pos = 0; ring_ticks = 0;
    pend_cycle = -1; pend_mask = 3'b000; e_alarm = 1'b0; m_prev = 1'b0;
  endtask

  task automatic clr_counts();
    cnt_sec = 0; cnt_min = 0; cnt_hour = 0; cnt_asec = 0; cnt_amin = 0; cnt_ahour = 0;
    first_sec = -1; last_sec = -1; bad_gap = 0; blink_on = 0; blink_off = 0; blink_other = 0;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge with this cycle's inputs applied; checks, then advances one cycle.
  task automatic step();
    int tick, heard;
    logic stk, cons, e0, e1, e2, rise, clr;
    logic sinc, minc, hinc, asi, ami, ahi;
    logic [2:0] pm;
    logic [5:0] xb;
    logic [16:0] exp_v, got_v;
    #1;
    tick = (n - base) % TICK_DIV;
    stk  = (e_mode != 1) && (tick == TICK_DIV - 1);
    pm   = (n == pend_cycle) ? pend_mask : 3'b000;
    cons = e_alarm && (pm != 3'b000);
    e0 = pm[0] && !cons;
    e1 = pm[1] && !pm[0] && !cons;
    e2 = pm[2] && !pm[1] && !pm[0] && !cons;
    if (e_mode == 1) begin
      sinc = e2 && (e_pos == 0);
      minc = e2 && (e_pos == 1);
      hinc = e2 && (e_pos == 2);
    end else begin
      sinc = stk;
      minc = stk && bus.i_sec_at_max;
      hinc = stk && bus.i_sec_at_max && bus.i_min_at_max;
    end
    asi = (e_mode == 2) && e2 && (e_pos == 0);
    ami = (e_mode == 2) && e2 && (e_pos == 1);
    ahi = (e_mode == 2) && e2 && (e_pos == 2);
    xb  = ((e_mode != 0) && (tick < TICK_DIV / 2)) ? (6'b000011 << (2 * e_pos)) : 6'b000000;
    exp_v = {2'(e_mode), 2'(e_pos), sinc, minc, hinc, asi, ami, ahi, xb, e_alarm};
    got_v = {bus.o_mode, bus.o_position, bus.o_sec_inc, bus.o_min_inc, bus.o_hour_inc,
             bus.o_alm_sec_inc, bus.o_alm_min_inc, bus.o_alm_hour_inc, bus.o_blink_mask, bus.o_alarm};
    tests++;
    assert (got_v === exp_v) else begin
      fails++;
      $error("FAIL cycle_outputs cyc=%0d: observed %h expected %h", n, got_v, exp_v);
    end

    if (bus.o_sec_inc) begin
      cnt_sec++;
      if (first_sec < 0) first_sec = n;
      if (last_sec >= 0 && (n - last_sec) != TICK_DIV) bad_gap++;
      last_sec = n;
    end
    if (bus.o_min_inc)      cnt_min++;
    if (bus.o_hour_inc)     cnt_hour++;
    if (bus.o_alm_sec_inc)  cnt_asec++;
    if (bus.o_alm_min_inc)  cnt_amin++;
    if (bus.o_alm_hour_inc) cnt_ahour++;
    if (bus.o_mode == 2'd1) begin
      if (bus.o_blink_mask == 6'b110000) blink_on++;
      else if (bus.o_blink_mask == 6'b000000) blink_off++;
      else blink_other++;
    end

    rise   = bus.i_alarm_match && !m_prev;
    m_prev = bus.i_alarm_match;
    heard  = ring_ticks + ((e_alarm && stk) ? 1 : 0);
    clr    = (pm != 3'b000) || (e_alarm && heard >= ALARM_SEC);
    if (clr) e_alarm = 1'b0;
    else if (rise && e_mode != 1) begin e_alarm = 1'b1; ring_ticks = 0; end
    else ring_ticks = heard;
    if (e0) begin
      if (e_mode == 1) base = n + 1;
      e_mode = (e_mode + 1) % 3;
      e_pos  = 0;
    end else if (e1) begin
      e_pos = (e_pos + 1) % 3;
    end
    @(negedge clk);
    n++;
  endtask

  // Pulse lands one cycle after the first strobe (cycle%4==3) at least two cycles after the pin drop.
  task automatic press(input logic [2:0] mask);
    int s;
    s = n + 2;
    while (s % SAMPLE_DIV != SAMPLE_DIV - 1) s++;
    pend_cycle = s + 1;
    pend_mask  = mask;
    if (mask[0]) bus.i_sw0 = 1'b0;
    if (mask[1]) bus.i_sw1 = 1'b0;
    if (mask[2]) bus.i_sw2 = 1'b0;
    while (n <= pend_cycle + 1) step();
    repeat ($urandom_range(0, 4)) step();
    bus.i_sw0 = 1'b1; bus.i_sw1 = 1'b1; bus.i_sw2 = 1'b1;
    repeat (8 + $urandom_range(0, 6)) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [16:0] got_v;
    #1;
    got_v = {bus.o_mode, bus.o_position, bus.o_sec_inc, bus.o_min_inc, bus.o_hour_inc,
             bus.o_alm_sec_inc, bus.o_alm_min_inc, bus.o_alm_hour_inc, bus.o_blink_mask, bus.o_alarm};
    chk(tag, int'(got_v), 0);
  endtask

  initial begin
    logic [2:0] rmask;
    int k;
    bus.i_sw0 = 1'b1; bus.i_sw1 = 1'b1; bus.i_sw2 = 1'b1;
    bus.i_sec_at_max = 1'b0; bus.i_min_at_max = 1'b0; bus.i_alarm_match = 1'b0;
    clr_counts();

    // Reset and idle
    @(negedge clk);
    check_reset_outputs("reset_outputs");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (100) step();
    chk("idle_first_sec_cycle", first_sec, TICK_DIV - 1);
    chk("idle_sec_count", cnt_sec, 10);
    chk("idle_gap_errors", bad_gap, 0);
    chk("idle_min_count", cnt_min + cnt_hour + cnt_asec + cnt_amin + cnt_ahour, 0);

    // Carry
    clr_counts();
    bus.i_sec_at_max = 1'b1; bus.i_min_at_max = 1'b1;
    repeat (TICK_DIV) step();
    chk("carry_sec", cnt_sec, 1);
    chk("carry_min", cnt_min, 1);
    chk("carry_hour", cnt_hour, 1);
    clr_counts();
    bus.i_min_at_max = 1'b0;
    repeat (TICK_DIV) step();
    chk("carry_min_only", cnt_min, 1);
    chk("carry_no_hour", cnt_hour, 0);
    for (int i = 0; i < 40; i++) begin
      bus.i_sec_at_max = 1'($urandom_range(0, 1));
      bus.i_min_at_max = 1'($urandom_range(0, 1));
      step();
    end

    // Setup: carries must be ignored
    bus.i_sec_at_max = 1'b1; bus.i_min_at_max = 1'b1;
    press(3'b001);
    chk("setup_mode", int'(bus.o_mode), 1);
    clr_counts();
    press(3'b010);
    press(3'b010);
    chk("setup_position", int'(bus.o_position), 2);
    chk("setup_no_sec_tick", cnt_sec, 0);
    clr_counts();
    press(3'b100);
    press(3'b100);
    press(3'b100);
    chk("setup_hour_incs", cnt_hour, 3);
    chk("setup_sec_min_incs", cnt_sec + cnt_min, 0);
    chk("setup_blink_on_seen", int'(blink_on > 0), 1);
    chk("setup_blink_off_seen", int'(blink_off > 0), 1);
    chk("setup_blink_other", blink_other, 0);

    // Simultaneous sw0+sw2 in SETUP
    bus.i_sec_at_max = 1'b0; bus.i_min_at_max = 1'b0;
    clr_counts();
    press(3'b101);
    chk("simul_mode", int'(bus.o_mode), 2);
    chk("simul_position", int'(bus.o_position), 0);
    chk("simul_no_inc", cnt_min + cnt_hour + cnt_asec + cnt_amin + cnt_ahour, 0);
    press(3'b001);
    chk("back_to_clock", int'(bus.o_mode), 0);

    // Alarm mode
    press(3'b001);
    press(3'b001);
    chk("alarm_mode", int'(bus.o_mode), 2);
    chk("alarm_mode_pos", int'(bus.o_position), 0);
    clr_counts();
    press(3'b100);
    repeat (30) step();
    chk("alarm_mode_alm_sec", cnt_asec, 1);
    chk("alarm_mode_other_alm", cnt_amin + cnt_ahour, 0);
    chk("alarm_mode_ticks_run", int'(cnt_sec >= 3), 1);
    chk("alarm_mode_tick_gaps", bad_gap, 0);
    for (int i = 0; i < 4; i++) begin
      k = $urandom_range(0, 2);
      rmask = (k == 0) ? 3'b010 : ((k == 1) ? 3'b100 : 3'b110);
      repeat ($urandom_range(0, 7)) step();
      press(rmask);
    end
    press(3'b001);
    chk("clock_again", int'(bus.o_mode), 0);

    // Alarm ring with auto clear
    bus.i_alarm_match = 1'b1;
    step();
    chk("ring_set", int'(bus.o_alarm), 1);
    clr_counts();
    k = 0;
    while (bus.o_alarm && k < 60) begin step(); k++; end
    chk("ring_auto_clear", int'(bus.o_alarm), 0);
    chk("ring_tick_count", cnt_sec, ALARM_SEC);
    bus.i_alarm_match = 1'b0;
    repeat (5) step();

    // Alarm cleared by a press that is consumed
    bus.i_alarm_match = 1'b1;
    step();
    chk("ring2_set", int'(bus.o_alarm), 1);
    bus.i_alarm_match = 1'b0;
    press(3'b010);
    chk("ring2_press_clear", int'(bus.o_alarm), 0);
    chk("ring2_pos_kept", int'(bus.o_position), 0);

    // No ringing in SETUP
    press(3'b001);
    bus.i_alarm_match = 1'b1;
    repeat (20) step();
    chk("setup_no_ring", int'(bus.o_alarm), 0);
    bus.i_alarm_match = 1'b0;
    step();

    // Reset mid-press with the button still held afterwards
    bus.i_sw0 = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    check_reset_outputs("midpress_reset_outputs");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (30) step();
    chk("held_no_press", int'(bus.o_mode), 0);
    bus.i_sw0 = 1'b1;
    repeat (10) step();
    press(3'b001);
    chk("repress_after_release", int'(bus.o_mode), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
